bcd_entry_to_binary: RTL

- Reverse path of the display chain: takes eight decimal digits plus a sign entered on board switches, and produces a 32-bit two's-complement word for the datapath.
- Typical use: an input-port / immediate-load source for the MIPS core.
- Sequential multiply-accumulate converter, one digit per clock, with a start/valid handshake.
- Optionally checks that every digit is a legal BCD value.

---
 rtl/bcd_entry_to_binary_pkg.sv | 8 +
 rtl/bcd_entry_to_binary_if.sv | 15 +
 rtl/bcd_entry_to_binary_mul10_add.sv | 10 +
 rtl/bcd_entry_to_binary.sv | 74 +++++++
 4 files changed

// File: rtl/bcd_entry_to_binary_pkg.sv
// bcd_entry_to_binary_pkg: shared constants and state encoding for the BCD entry/display chain.
package bcd_entry_to_binary_pkg;
  typedef enum logic [1:0] {IDLE, CONV, SIGN} state_t;
  localparam int BCD_W = 4;
  localparam int DEF_NDIGITS = 8;
  localparam int DEF_WIDTH = 32;
  localparam int DEC10 = 10;
endpackage

// File: rtl/bcd_entry_to_binary_if.sv
// bcd_entry_to_binary_if: start/valid handshake between a requester and the BCD-to-binary converter.
interface bcd_entry_to_binary_if import bcd_entry_to_binary_pkg::*; #(
  parameter int NDIGITS = DEF_NDIGITS,
  parameter int WIDTH = DEF_WIDTH
);
  logic start;
  logic [BCD_W*NDIGITS-1:0] digits;
  logic neg;
  logic busy;
  logic valid;
  logic [WIDTH-1:0] result;
  logic err;
  modport master (output start, digits, neg, input busy, valid, result, err);
  modport slave (input start, digits, neg, output busy, valid, result, err);
endinterface

// File: rtl/bcd_entry_to_binary_mul10_add.sv
// bcd_entry_to_binary_mul10_add: combinational acc*10+digit step using shift-and-add.
module bcd_entry_to_binary_mul10_add import bcd_entry_to_binary_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic [WIDTH-1:0] i_acc,
  input  logic [BCD_W-1:0] i_digit,
  output logic [WIDTH-1:0] o_sum
);
  assign o_sum = (i_acc << 3) + (i_acc << 1) + WIDTH'(i_digit);
endmodule

// File: rtl/bcd_entry_to_binary.sv
// bcd_entry_to_binary: sequential signed-BCD to two's-complement converter, one digit per clock.
// Define BCD_CHECK_EN to reject entries containing a nibble above 9.
module bcd_entry_to_binary import bcd_entry_to_binary_pkg::*; #(
  parameter int NDIGITS = DEF_NDIGITS,
  parameter int WIDTH = DEF_WIDTH
) (
  input logic clk,
  input logic rst_n,
  bcd_entry_to_binary_if.slave bus
);
  localparam int CW = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;
  state_t r_state, w_next;
  logic [BCD_W*NDIGITS-1:0] r_dreg;
  logic r_neg, r_valid, r_err, w_bad;
  logic [WIDTH-1:0] r_acc, r_result, w_sum;
  logic [CW-1:0] r_cnt;
  logic [BCD_W-1:0] w_digit;
  assign w_digit = r_dreg[r_cnt*BCD_W +: BCD_W];
  bcd_entry_to_binary_mul10_add #(.WIDTH(WIDTH)) u_mac (.i_acc(r_acc), .i_digit(w_digit), .o_sum(w_sum));
`ifdef BCD_CHECK_EN
  always_comb begin
    w_bad = 1'b0;
    for (int i = 0; i < NDIGITS; i++) w_bad = w_bad | (bus.digits[i*BCD_W +: BCD_W] > BCD_W'(DEC10 - 1));
  end
`else
  assign w_bad = 1'b0;
`endif
  always_comb begin
    w_next = (r_state == IDLE) ? ((bus.start && !w_bad) ? CONV : IDLE) :
             (r_state == CONV) ? ((r_cnt == '0) ? SIGN : CONV) : IDLE;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_dreg <= '0;
      r_neg <= 1'b0;
      r_acc <= '0;
      r_cnt <= '0;
      r_result <= '0;
      r_valid <= 1'b0;
      r_err <= 1'b0;
    end else begin
      r_state <= w_next;
      r_valid <= 1'b0;
      case (r_state)
        IDLE: if (bus.start) begin
          r_dreg <= bus.digits;
          r_neg <= bus.neg;
          r_acc <= '0;
          r_cnt <= CW'(NDIGITS - 1);
          if (w_bad) begin
            r_valid <= 1'b1;
            r_err <= 1'b1;
            r_result <= '0;
          end
        end
        CONV: begin
          r_acc <= w_sum;
          r_cnt <= r_cnt - 1'b1;
        end
        SIGN: begin
          r_result <= r_neg ? ~r_acc + WIDTH'(1) : r_acc;
          r_err <= 1'b0;
          r_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end
  assign bus.busy = (r_state != IDLE);
  assign bus.valid = r_valid;
  assign bus.result = r_result;
  assign bus.err = r_err;
endmodule
